bus_reg_sink: RTL and testbench
===============================

Name: bus_reg_sink

Overview:
- Receiving end of the datapath bus: the general-purpose register file that loads from BusMuxOut, plus the select-and-encode logic that drives per-register in/out enables.
- Decodes register fields from IR under Gra/Grb/Grc.
- Registers the bus value into the selected register on Rin.
- Produces the one-hot out-enable vector and read data that feed the bus mux.
- Also supplies the sign-extended C constant.

Parameters:
- DATA_WIDTH, 32, bus and register width.
- NUM_REGS, 16, number of general-purpose registers (index width 4).
- CNT_WIDTH, 8, width of the accepted-write counter.

Ports:
- clock  input  1  system clock, rising-edge.
- clear  input  1  reset, synchronous, active-high.
- BusMuxOut  input  DATA_WIDTH  bus value to load.
- IR  input  32  instruction register; Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Gra, Grb, Grc  input  1 each  field select strobes.
- Rin  input  1  load selected register from bus.
- Rout  input  1  drive selected register onto bus.
- BAout  input  1  like Rout, but R0 reads as zero.
- Rin_onehot  output  NUM_REGS  per-register load enables.
- Rout_onehot  output  NUM_REGS  per-register out-enables to the bus encoder.
- RegReadData  output  DATA_WIDTH  value of the selected register for the bus mux.
- C_sign_extended  output  DATA_WIDTH  IR[18:0] sign-extended.
- wr_valid  output  1  registered pulse, one cycle after each accepted write.
- last_wr_idx  output  4  index of the most recent accepted write.
- wr_count  output  CNT_WIDTH  accepted-write counter.
- sel_err  output  1  sticky selection-error flag.

Behaviour:
- Selection (combinational):
  - sel_valid = Gra|Grb|Grc.
  - idx = Ra if Gra, else Rb if Grb, else Rc (priority Gra > Grb > Grc).
- Rin_onehot = decode(idx) when Rin & sel_valid, else 0.
- Rout_onehot = decode(idx) when (Rout|BAout) & sel_valid, else 0.
- RegReadData (combinational):
  - regs[idx] when (Rout|BAout) & sel_valid.
  - Forced to 0 when BAout & idx==0.
  - 0 when no out-enable is active.
- C_sign_extended = {13{IR[18]}, IR[18:0]}, combinational.
- Write: at rising clock, if !clear & Rin & sel_valid, regs[idx] <= BusMuxOut. R0 is writable; only BAout masks it.
- Read/write same register same cycle: RegReadData shows the old value; the new value is visible the next cycle (no bypass).
- Rin without sel_valid: no write, no count, no wr_valid.
- Write side effects, registered on the cycle of the accepted write (write cycle N):
  - wr_valid = 1 in cycle N+1, 0 otherwise.
  - last_wr_idx = idx.
  - wr_count += 1, wrapping from 2^CNT_WIDTH-1 to 0.
- Reset: clear overrides every other input in the same cycle, including Rin; no write happens. All of the following go to 0 on the next edge:
  - all regs
  - wr_valid
  - last_wr_idx
  - wr_count
  - sel_err
- Combinational outputs track their inputs even during clear; RegReadData then reflects the zeroed registers after the edge.

Optional Feature:
- Macro SEL_ERR_EN.
- Defined: sel_err is set at a rising clock when either condition holds:
  - more than one of Gra/Grb/Grc is high;
  - Rin or Rout or BAout is high with sel_valid=0.
- Once set, sel_err is sticky until clear.
- The priority resolution above still applies; the flag never blocks a write.
- Not defined: sel_err is tied to 0 and no error logic is built.

Test Plan:
- Write/read: clear 1 cycle; IR Ra=5; Gra=1, Rin=1, BusMuxOut=0xDEADBEEF for 1 cycle -> next cycle Rout=1 gives RegReadData=0xDEADBEEF, Rout_onehot=0x0020, wr_valid=1, last_wr_idx=5, wr_count=1.
- BAout masking: write 0x12345678 to R0 via Grb; then BAout=1 with Rb=0 -> RegReadData=0, Rout_onehot=0x0001; Rout=1 instead -> 0x12345678.
- Same-cycle read/write: R3=0x1 preloaded; Grc with Rc=3, Rin=1, Rout=1, BusMuxOut=0x2 -> RegReadData=0x1 that cycle, 0x2 the next.
- Priority and error: Gra+Grb both high, Ra=2, Rb=7, Rin=1, BusMuxOut=0xAA -> R2=0xAA, R7 unchanged, Rin_onehot=0x0004; with SEL_ERR_EN, sel_err=1 and stays 1 until clear.
- Counter wrap and clear: 256 accepted writes -> wr_count=0 (CNT_WIDTH=8); assert clear together with Rin -> no write, all regs and outputs 0 next cycle.
- Sign extend: IR[18:0]=0x40000 -> C_sign_extended=0xFFFC0000; IR[18:0]=0x3FFFF -> 0x0003FFFF.

Source files
------------

// File: rtl/bus_reg_sink.sv
// rtl/bus_reg_sink.sv - general-purpose register file and select/encode logic at the receiving end of the bus
// Optional sticky selection-error detection is built only when SEL_ERR_EN is defined.
module bus_reg_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic [31:0]           IR,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  output logic [NUM_REGS-1:0]   Rin_onehot,
  output logic [NUM_REGS-1:0]   Rout_onehot,
  output logic [DATA_WIDTH-1:0] RegReadData,
  output logic [DATA_WIDTH-1:0] C_sign_extended,
  output logic                  wr_valid,
  output logic [3:0]            last_wr_idx,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  sel_err
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  wr_valid_q, wr_valid_d;
  logic [3:0]            last_wr_idx_q, last_wr_idx_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;

  logic       sel_valid;
  logic [3:0] idx;
  logic       wr_en;
  logic       out_en;
  logic       unused_ir;

  assign sel_valid = Gra | Grb | Grc;
  assign idx       = Gra ? IR[26:23] : (Grb ? IR[22:19] : IR[18:15]);
  assign wr_en     = Rin & sel_valid;
  assign out_en    = (Rout | BAout) & sel_valid;
  assign unused_ir = ^IR[31:27];

  assign Rin_onehot      = wr_en  ? (NUM_REGS'(1) << idx) : '0;
  assign Rout_onehot     = out_en ? (NUM_REGS'(1) << idx) : '0;
  assign C_sign_extended = {{(DATA_WIDTH-19){IR[18]}}, IR[18:0]};

  // BAout treats R0 as a literal zero for base-address arithmetic.
  always_comb begin
    RegReadData = '0;
    if (out_en && !(BAout && idx == 4'd0)) begin
      RegReadData = regs_q[idx];
    end
  end

  always_comb begin
    regs_d        = regs_q;
    wr_valid_d    = 1'b0;
    last_wr_idx_d = last_wr_idx_q;
    wr_count_d    = wr_count_q;
    if (wr_en) begin
      regs_d[idx]   = BusMuxOut;
      wr_valid_d    = 1'b1;
      last_wr_idx_d = idx;
      wr_count_d    = wr_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_valid_q    <= 1'b0;
      last_wr_idx_q <= '0;
      wr_count_q    <= '0;
    end else begin
      regs_q        <= regs_d;
      wr_valid_q    <= wr_valid_d;
      last_wr_idx_q <= last_wr_idx_d;
      wr_count_q    <= wr_count_d;
    end
  end

  assign wr_valid    = wr_valid_q;
  assign last_wr_idx = last_wr_idx_q;
  assign wr_count    = wr_count_q;

`ifdef SEL_ERR_EN
  logic sel_err_q, sel_err_d;
  logic multi_sel;

  assign multi_sel = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);

  always_comb begin
    sel_err_d = sel_err_q;
    if (multi_sel || ((Rin | Rout | BAout) && !sel_valid)) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_reg_sink.sv
// tb/tb_bus_reg_sink.sv - scoreboard bench for bus_reg_sink
// Expected write side effects and reads are queued by stimulus; a negedge monitor pops and compares.
module tb_bus_reg_sink;

  logic        clock;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic [31:0] IR;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic [15:0] Rin_onehot, Rout_onehot;
  logic [31:0] RegReadData, C_sign_extended;
  logic        wr_valid;
  logic [3:0]  last_wr_idx;
  logic [7:0]  wr_count;
  logic        sel_err;

  bus_reg_sink dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .IR(IR),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Rin_onehot(Rin_onehot), .Rout_onehot(Rout_onehot), .RegReadData(RegReadData),
    .C_sign_extended(C_sign_extended), .wr_valid(wr_valid), .last_wr_idx(last_wr_idx),
    .wr_count(wr_count), .sel_err(sel_err)
  );

`ifdef SEL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct { logic [3:0] idx; logic [7:0] cnt; } wexp_t;
  typedef struct { logic [31:0] data; logic [15:0] oh; } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int total = 0;
  int bad = 0;
  logic [7:0] exp_cnt = 8'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ir_of(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    return {5'b0, ra, rb, rc, 15'b0};
  endfunction

  task automatic drive(input logic ga, input logic gb, input logic gc, input logic rin,
                       input logic rout, input logic ba, input logic [31:0] ir, input logic [31:0] bus);
    Gra = ga; Grb = gb; Grc = gc; Rin = rin; Rout = rout; BAout = ba; IR = ir; BusMuxOut = bus;
  endtask

  task automatic push_wr(input logic [3:0] idx);
    wexp_t w;
    exp_cnt = exp_cnt + 8'd1;
    w.idx = idx;
    w.cnt = exp_cnt;
    wq.push_back(w);
  endtask

  task automatic push_rd(input logic [31:0] data, input logic [15:0] oh);
    rexp_t r;
    r.data = data;
    r.oh = oh;
    rq.push_back(r);
  endtask

  // Monitor: every wr_valid pulse and every active out-enable must match a queued expectation.
  always @(negedge clock) begin
    if (wr_valid === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_wr_valid", {31'b0, wr_valid}, 32'd0);
      end else begin
        wexp_t w;
        w = wq.pop_front();
        chk("last_wr_idx", {28'b0, last_wr_idx}, {28'b0, w.idx});
        chk("wr_count", {24'b0, wr_count}, {24'b0, w.cnt});
      end
    end
    if (Rout_onehot !== 16'h0) begin
      if (rq.size() == 0) begin
        chk("unexpected_read", {16'b0, Rout_onehot}, 32'd0);
      end else begin
        rexp_t r;
        r = rq.pop_front();
        chk("RegReadData", RegReadData, r.data);
        chk("Rout_onehot", {16'b0, Rout_onehot}, {16'b0, r.oh});
      end
    end
  end

  initial begin
    clear = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    clear = 1'b0;
    chk("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
    chk("rst_wr_count", {24'b0, wr_count}, 32'd0);
    chk("rst_last_idx", {28'b0, last_wr_idx}, 32'd0);
    chk("rst_sel_err", {31'b0, sel_err}, 32'd0);
    chk("rst_read", RegReadData, 32'd0);

    // Write R5 via Gra, then read it back.
    drive(1, 0, 0, 1, 0, 0, ir_of(4'd5, 4'd0, 4'd0), 32'hDEADBEEF);
    #1 chk("rin_onehot_r5", {16'b0, Rin_onehot}, 32'h0020);
    push_wr(4'd5);
    tick;
    drive(1, 0, 0, 0, 1, 0, ir_of(4'd5, 4'd0, 4'd0), 32'h0);
    push_rd(32'hDEADBEEF, 16'h0020);
    tick;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    chk("wr_valid_single_pulse", {31'b0, wr_valid}, 32'd0);

    // R0 via Grb, BAout masks, Rout does not.
    drive(0, 1, 0, 1, 0, 0, ir_of(4'd0, 4'd0, 4'd0), 32'h12345678);
    push_wr(4'd0);
    tick;
    drive(0, 1, 0, 0, 0, 1, ir_of(4'd0, 4'd0, 4'd0), 32'h0);
    push_rd(32'h0, 16'h0001);
    tick;
    drive(0, 1, 0, 0, 1, 0, ir_of(4'd0, 4'd0, 4'd0), 32'h0);
    push_rd(32'h12345678, 16'h0001);
    tick;

    // Same-cycle read/write of R3 via Grc: old value now, new value next.
    drive(0, 0, 1, 1, 0, 0, ir_of(4'd0, 4'd0, 4'd3), 32'h1);
    push_wr(4'd3);
    tick;
    drive(0, 0, 1, 1, 1, 0, ir_of(4'd0, 4'd0, 4'd3), 32'h2);
    push_wr(4'd3);
    push_rd(32'h1, 16'h0008);
    tick;
    drive(0, 0, 1, 0, 1, 0, ir_of(4'd0, 4'd0, 4'd3), 32'h0);
    push_rd(32'h2, 16'h0008);
    tick;

    // Gra and Grb together: Ra wins.
    drive(1, 1, 0, 1, 0, 0, ir_of(4'd2, 4'd7, 4'd0), 32'hAA);
    #1 chk("rin_onehot_prio", {16'b0, Rin_onehot}, 32'h0004);
    push_wr(4'd2);
    tick;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("sel_err_set", {31'b0, sel_err}, {31'b0, EXP_ERR});
    drive(1, 0, 0, 0, 1, 0, ir_of(4'd2, 4'd0, 4'd0), 32'h0);
    push_rd(32'hAA, 16'h0004);
    tick;
    drive(0, 1, 0, 0, 1, 0, ir_of(4'd0, 4'd7, 4'd0), 32'h0);
    push_rd(32'h0, 16'h0080);
    tick;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    chk("sel_err_sticky", {31'b0, sel_err}, {31'b0, EXP_ERR});

    // 256 more writes bring the counter back around to the same value.
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 0, 1, 0, 0, ir_of(4'd9, 4'd0, 4'd0), i);
      push_wr(4'd9);
      tick;
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    chk("wr_count_wrapped", {24'b0, wr_count}, 32'd5);

    // clear beats Rin in the same cycle.
    clear = 1'b1;
    drive(1, 0, 0, 1, 0, 0, ir_of(4'd9, 4'd0, 4'd0), 32'hFFFFFFFF);
    tick;
    clear = 1'b0;
    exp_cnt = 8'd0;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("clr_wr_valid", {31'b0, wr_valid}, 32'd0);
    chk("clr_wr_count", {24'b0, wr_count}, 32'd0);
    chk("clr_last_idx", {28'b0, last_wr_idx}, 32'd0);
    chk("clr_sel_err", {31'b0, sel_err}, 32'd0);
    drive(1, 0, 0, 0, 1, 0, ir_of(4'd9, 4'd0, 4'd0), 32'h0);
    push_rd(32'h0, 16'h0200);
    tick;
    drive(1, 0, 0, 0, 1, 0, ir_of(4'd2, 4'd0, 4'd0), 32'h0);
    push_rd(32'h0, 16'h0004);
    tick;

    // Sign extension of the C field.
    drive(0, 0, 0, 0, 0, 0, 32'h00040000, 32'h0);
    #1 chk("c_sext_neg", C_sign_extended, 32'hFFFC0000);
    drive(0, 0, 0, 0, 0, 0, 32'h0003FFFF, 32'h0);
    #1 chk("c_sext_pos", C_sign_extended, 32'h0003FFFF);
    tick;
    tick;

    chk("write_queue_drained", wq.size(), 32'd0);
    chk("read_queue_drained", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
